// File: rtl/energy_detector_pkg.sv
// Shared types and constants for the energy detector slice.
package energy_detector_pkg;

  localparam int DEF_WIDTH    = 30;
  localparam int DEF_AVG_LOG2 = 3;
  localparam int DEF_HOLD_WIN = 4;
  localparam int COUNT_W      = 16;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    TRACK_OFF = 2'd1,
    TRACK_ON  = 2'd2
  } det_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/energy_detector_pulse_sync.sv
// Two-flop synchroniser for an asynchronous level followed by a rising-edge
// pulse generator. RESET_VAL = 1 makes a level that is already high when reset
// releases count as "old", so only a genuine new rise produces a pulse.
module pulse_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);
  import energy_detector_pkg::*;

  logic sync1;
  logic sync2;
  logic prev;

  // Metastability chain plus one stage of history for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
      prev  <= RESET_VAL;
    end else begin
      sync1 <= level;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/energy_detector.sv
// Captures completed window energies, keeps a moving average over the last
// DEPTH windows and makes a hysteretic signal-present decision with a minimum
// hold time after each assertion.
module energy_detector
  import energy_detector_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AVG_LOG2 = DEF_AVG_LOG2,
  parameter int HOLD_WIN = DEF_HOLD_WIN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   energy_in,
  input  logic               energy_complete,
  input  logic [WIDTH-2:0]   thresh_on,
  input  logic [WIDTH-2:0]   thresh_off,
  input  logic               flush,
  output logic [WIDTH-2:0]   avg_out,
  output logic               avg_valid,
  output logic               detect,
  output logic               detect_rise,
  output logic               detect_fall,
  output logic [COUNT_W-1:0] window_count,
  output logic               neg_seen
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = WIDTH - 1 + AVG_LOG2;
  localparam int HOLD_W = $clog2(HOLD_WIN + 1);

  logic                evt;
  logic [WIDTH-2:0]    val;
  logic [WIDTH-2:0]    buffer [DEPTH];
  logic [AVG_LOG2-1:0] wr;
  logic [SUM_W-1:0]    sum;
  logic                pending;
  logic [WIDTH-2:0]    avg_next;
  logic                go_on;
  logic [HOLD_W-1:0]   hold;
  det_state_t          state;

  pulse_sync #(
    .RESET_VAL(1'b1)
  ) u_complete_sync (
    .clk  (clk),
    .reset(reset),
    .level(energy_complete),
    .pulse(evt)
  );

  assign val      = energy_in[WIDTH-1] ? '0 : energy_in[WIDTH-2:0];
  assign avg_next = sum[SUM_W-1:AVG_LOG2];
  assign go_on    = (avg_next >= thresh_on);

  // Stage 1: write the new window into the ring and update the running sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
      wr           <= '0;
      sum          <= '0;
      pending      <= 1'b0;
      window_count <= '0;
      neg_seen     <= 1'b0;
    end else begin
      pending <= 1'b0;
      if (evt && energy_in[WIDTH-1]) neg_seen <= 1'b1;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
        wr           <= '0;
        sum          <= '0;
        window_count <= '0;
      end else if (evt) begin
        buffer[wr]   <= val;
        sum          <= sum + SUM_W'(val) - SUM_W'(buffer[wr]);
        wr           <= wr + AVG_LOG2'(1);
        window_count <= sat_inc(window_count);
        pending      <= 1'b1;
      end
    end
  end

  // Stage 2: publish the average and run the hysteresis/hold decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      avg_out     <= '0;
      avg_valid   <= 1'b0;
      detect      <= 1'b0;
      detect_rise <= 1'b0;
      detect_fall <= 1'b0;
      hold        <= '0;
    end else begin
      avg_valid   <= 1'b0;
      detect_rise <= 1'b0;
      detect_fall <= 1'b0;
      if (flush) begin
        state  <= FILL;
        detect <= 1'b0;
        hold   <= '0;
      end else if (pending) begin
        case (state)
          FILL: begin
            if (window_count >= COUNT_W'(DEPTH)) begin
              avg_out   <= avg_next;
              avg_valid <= 1'b1;
              if (go_on) begin
                detect      <= 1'b1;
                detect_rise <= 1'b1;
                hold        <= HOLD_W'(HOLD_WIN);
                state       <= TRACK_ON;
              end else begin
                state <= TRACK_OFF;
              end
            end
          end
          TRACK_OFF: begin
            avg_out   <= avg_next;
            avg_valid <= 1'b1;
            if (go_on) begin
              detect      <= 1'b1;
              detect_rise <= 1'b1;
              hold        <= HOLD_W'(HOLD_WIN);
              state       <= TRACK_ON;
            end
          end
          TRACK_ON: begin
            avg_out   <= avg_next;
            avg_valid <= 1'b1;
            if (hold != '0) begin
              hold <= hold - HOLD_W'(1);
            end else if (avg_next < thresh_off) begin
              detect      <= 1'b0;
              detect_fall <= 1'b1;
              state       <= TRACK_OFF;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_energy_detector.sv
// Directed bench for energy_detector: the stimulus side queues the expected
// average/decision for each window, a monitor checks them as avg_valid appears.
module tb_energy_detector;

  logic        clk;
  logic        reset;
  logic [29:0] energy_in;
  logic        energy_complete;
  logic [28:0] thresh_on;
  logic [28:0] thresh_off;
  logic        flush;
  logic [28:0] avg_out;
  logic        avg_valid;
  logic        detect;
  logic        detect_rise;
  logic        detect_fall;
  logic [15:0] window_count;
  logic        neg_seen;

  typedef struct {
    logic [28:0] avg;
    logic        det;
    logic        rise;
    logic        fall;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   checks = 0;
  int   fails = 0;
  int   fall_seen = 0;

  energy_detector dut (
    .clk            (clk),
    .reset          (reset),
    .energy_in      (energy_in),
    .energy_complete(energy_complete),
    .thresh_on      (thresh_on),
    .thresh_off     (thresh_off),
    .flush          (flush),
    .avg_out        (avg_out),
    .avg_valid      (avg_valid),
    .detect         (detect),
    .detect_rise    (detect_rise),
    .detect_fall    (detect_fall),
    .window_count   (window_count),
    .neg_seen       (neg_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // One complete window: optional expected result queued, then the complete
  // level held for four cycles and released for four.
  task automatic applyStimulus(input logic [29:0] e, input bit has_out, input logic [28:0] a,
                               input logic d, input logic r, input logic f, input logic [15:0] c);
    exp_t x;
    if (has_out) begin
      x.avg = a;
      x.det = d;
      x.rise = r;
      x.fall = f;
      x.cnt = c;
      sb.push_back(x);
    end
    energy_in = e;
    energy_complete = 1'b1;
    repeat (4) @(negedge clk);
    energy_complete = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Monitor: every avg_valid must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (avg_valid) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_avg_valid: got avg %0d expected no output", avg_out);
        end else begin
          mon_x = sb.pop_front();
          checkOutput("avg_out", 32'(avg_out), 32'(mon_x.avg));
          checkOutput("flags_det_rise_fall", {29'd0, detect, detect_rise, detect_fall},
                      {29'd0, mon_x.det, mon_x.rise, mon_x.fall});
          checkOutput("window_count_at_valid", 32'(window_count), 32'(mon_x.cnt));
        end
      end else if (detect_rise || detect_fall) begin
        checks++;
        fails++;
        $display("[TB] FAIL stray_pulse: got rise %0b fall %0b expected none", detect_rise, detect_fall);
      end
      if (detect_fall) fall_seen++;
    end
  end

  initial begin
    reset = 1'b1;
    energy_in = '0;
    energy_complete = 1'b0;
    thresh_on = 29'd2000;
    thresh_off = 29'd1500;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_avg_out", 32'(avg_out), 0);
    checkOutput("reset_flags", {27'd0, avg_valid, detect, detect_rise, detect_fall, neg_seen}, 0);
    checkOutput("reset_window_count", 32'(window_count), 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] reset in the middle of a window");
    energy_in = 30'd7777;
    energy_complete = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_window_count", 32'(window_count), 0);
    checkOutput("midreset_flags", {28'd0, avg_valid, detect, neg_seen, detect_rise}, 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("no_evt_while_high", 32'(window_count), 0);
    energy_complete = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] fill with 1000");
    for (int i = 1; i <= 8; i++)
      applyStimulus(30'd1000, (i == 8), 29'd1000, 1'b0, 1'b0, 1'b0, 16'(i));
    checkOutput("fill_window_count", 32'(window_count), 8);

    $display("[TB] windows of 3000");
    applyStimulus(30'd3000, 1'b1, 29'd1250, 1'b0, 1'b0, 1'b0, 16'd9);
    applyStimulus(30'd3000, 1'b1, 29'd1500, 1'b0, 1'b0, 1'b0, 16'd10);
    applyStimulus(30'd3000, 1'b1, 29'd1750, 1'b0, 1'b0, 1'b0, 16'd11);
    applyStimulus(30'd3000, 1'b1, 29'd2000, 1'b1, 1'b1, 1'b0, 16'd12);
    checkOutput("detect_after_rise", 32'(detect), 1);

    $display("[TB] windows of 0");
    applyStimulus(30'd0, 1'b1, 29'd1875, 1'b1, 1'b0, 1'b0, 16'd13);
    applyStimulus(30'd0, 1'b1, 29'd1750, 1'b1, 1'b0, 1'b0, 16'd14);
    applyStimulus(30'd0, 1'b1, 29'd1625, 1'b1, 1'b0, 1'b0, 16'd15);
    applyStimulus(30'd0, 1'b1, 29'd1500, 1'b1, 1'b0, 1'b0, 16'd16);
    applyStimulus(30'd0, 1'b1, 29'd1125, 1'b0, 1'b0, 1'b1, 16'd17);
    applyStimulus(30'd0, 1'b1, 29'd750, 1'b0, 1'b0, 1'b0, 16'd18);
    checkOutput("detect_after_fall", 32'(detect), 0);

    $display("[TB] negative energy clamp");
    checkOutput("neg_seen_before", 32'(neg_seen), 0);
    applyStimulus(30'h2000_0000, 1'b1, 29'd375, 1'b0, 1'b0, 1'b0, 16'd19);
    checkOutput("neg_seen_set", 32'(neg_seen), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_window_count", 32'(window_count), 0);
    checkOutput("neg_seen_after_flush", 32'(neg_seen), 1);
    checkOutput("detect_after_flush", 32'(detect), 0);

    $display("[TB] flush coincident with evt");
    applyStimulus(30'd5000, 1'b0, 29'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    applyStimulus(30'd5000, 1'b0, 29'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("prefill_window_count", 32'(window_count), 2);
    energy_in = 30'd9000;
    energy_complete = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    energy_complete = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("flush_evt_window_count", 32'(window_count), 0);
    for (int i = 1; i <= 8; i++)
      applyStimulus(30'd100, (i == 8), 29'd100, 1'b0, 1'b0, 1'b0, 16'(i));
    checkOutput("refill_window_count", 32'(window_count), 8);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 0);
    checkOutput("fall_pulse_count", 32'(fall_seen), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
